// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter.
//   - Parity-mode constants (none / even / odd).
//   - Transmit state encoding.
//   - Parity helper computed over a configurable number of data bits.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // XOR of the low nbits of data; inverted for odd parity.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input int unsigned nbits,
                                       input int unsigned mode);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return (mode == PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, single clock, synchronous active-high reset.
// Ports:
//   clk, rst       clock and synchronous reset
//   push, wdata    write request and data (accepted when not full, or when
//                  a pop happens in the same cycle)
//   pop            read request (ignored while empty)
//   rdata          head entry (combinational from storage)
//   full, empty    status from the registered count
//   count          number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is only safe when the head leaves this cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a transmit FIFO and register interface.
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   brg_full  baud tick, one pulse per bit period
//   iocs      chip select
//   iorw      0 = write, 1 = read
//   ioaddr    register select: 0 = transmit data, 1 = control (bit0 clears ovf)
//   databus   write data, bits [DATA_BITS-1:0] used for transmit data
//   tbr       1 = FIFO can accept a byte
//   txd       serial output, registered, idle high
//   tx_busy   1 = frame in progress
//   ovf       sticky overflow flag
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       brg_full,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] databus,
  output logic       tbr,
  output logic       txd,
  output logic       tx_busy,
  output logic       ovf
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e              state_q, state_d;
  logic                   txd_q, txd_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   ovf_q, ovf_d;

  logic                   push;
  logic                   pop;
  logic                   clr_ovf;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [7:0]             head_ext;
  logic                   unused_bits;

  assign push    = iocs & ~iorw & (ioaddr == 2'd0);
  assign clr_ovf = iocs & ~iorw & (ioaddr == 2'd1) & databus[0];

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (databus[DATA_BITS-1:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign unused_bits = ^{databus, fifo_count};

  always_comb begin
    head_ext                = '0;
    head_ext[DATA_BITS-1:0] = fifo_rdata;
  end

  // Transmit FSM: every transition is gated by the baud tick.
  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    pop        = 1'b0;

    if (brg_full) begin
      case (state_q)
        ST_IDLE: begin
          txd_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_START;
            txd_d   = 1'b0;
          end
        end
        ST_START: begin
          state_d   = ST_DATA;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
        ST_DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_MODE != PARITY_NONE) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d    = ST_STOP;
              txd_d      = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          state_d    = ST_STOP;
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
        end
        ST_STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            if (!fifo_empty) begin
              // Back-to-back frame: start bit follows the last stop bit.
              pop     = 1'b1;
              state_d = ST_START;
              txd_d   = 1'b0;
            end else begin
              state_d = ST_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end

    // Every pop loads a fresh frame; parity is captured with the data.
    if (pop) begin
      shift_d = fifo_rdata;
      par_d   = calc_parity(head_ext, DATA_BITS, PARITY_MODE);
    end
  end

  // Overflow flag: a dropped push sets it and wins over a clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      txd_q      <= 1'b1;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = (state_q != ST_IDLE);
  assign ovf     = ovf_q;
  assign tbr     = ~fifo_full;

endmodule
